// File: rtl/data_mem_unit_if.sv
// ============================================================================
// Module      : data_mem_unit_if
// Description : Request/response bus and program-output FIFO signals of the
//               data memory unit. The slave modport is the memory side; the
//               master modport is the requester/consumer side.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_mem_unit_if;
  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Response channel
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  // Program-output FIFO head
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err,
    output out_valid, out_data,
    input  out_ready
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_unit.sv
// ============================================================================
// Module      : data_mem_unit
// Description : Byte-addressable little-endian data RAM with byte/half/word
//               loads and stores, alignment and range checking, and a
//               memory-mapped program-output FIFO at MMIO_ADDR.
//               Optional macro DMEM_PROGRAM_DISPLAY_EN prints every MMIO push.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_unit #(
  parameter int          ADDR_W    = 17,
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF_0000,
  parameter int          OUT_DEPTH = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  data_mem_unit_if.slave      bus
);

  localparam int c_MEM_BYTES = 1 << ADDR_W;
  localparam int c_PW        = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int c_CW        = $clog2(OUT_DEPTH + 1);

  // Backing RAM starts out zeroed; reset never touches it.
  logic [7:0]  r_mem [0:c_MEM_BYTES-1] = '{default: 8'h00};

  logic [31:0] r_fifo [0:OUT_DEPTH-1];
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;

  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_data;

  logic [ADDR_W-1:0] w_idx;
  logic        w_is_mmio;
  logic        w_oob;
  logic        w_err;
  logic        w_full;
  logic        w_ready;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_mem_we;
  logic [3:0]  w_be;
  logic [7:0]  w_b0, w_b1, w_b2, w_b3;
  logic [31:0] w_load;

  assign w_idx     = bus.req_addr[ADDR_W-1:0];
  assign w_is_mmio = (bus.req_addr == MMIO_ADDR);
  assign w_oob     = |bus.req_addr[31:ADDR_W];
  assign w_full    = (r_count == c_CW'(OUT_DEPTH));

  // The MMIO port bypasses size and alignment checks; everything else faults
  // on an illegal size, misalignment or an address beyond the RAM.
  assign w_err = !w_is_mmio &&
                 ((bus.req_size == 2'b11) ||
                  (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                  (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                  w_oob);

  // Only an MMIO store into a full FIFO stalls; a same-cycle pop does not help.
  assign w_ready  = !(bus.req_valid && bus.req_write && w_is_mmio && w_full);
  assign w_accept = bus.req_valid && w_ready && !reset;
  assign w_push   = w_accept && bus.req_write && w_is_mmio;
  assign w_pop    = (r_count != '0) && bus.out_ready && !reset;
  assign w_mem_we = w_accept && bus.req_write && !w_is_mmio && !w_err;

  // Byte-lane enables and sign/zero-extended load result for the current request.
  always_comb begin
    w_be   = 4'b0000;
    w_b0   = r_mem[w_idx];
    w_b1   = r_mem[w_idx + ADDR_W'(1)];
    w_b2   = r_mem[w_idx + ADDR_W'(2)];
    w_b3   = r_mem[w_idx + ADDR_W'(3)];
    w_load = '0;
    case (bus.req_size)
      2'b00: begin
        w_be   = 4'b0001;
        w_load = bus.req_unsigned ? {24'h0, w_b0} : {{24{w_b0[7]}}, w_b0};
      end
      2'b01: begin
        w_be   = 4'b0011;
        w_load = bus.req_unsigned ? {16'h0, w_b1, w_b0}
                                  : {{16{w_b1[7]}}, w_b1, w_b0};
      end
      default: begin
        w_be   = 4'b1111;
        w_load = {w_b3, w_b2, w_b1, w_b0};
      end
    endcase
    if (w_is_mmio) begin
      w_load = 32'(r_count);
    end
  end

  // RAM byte-lane writes; only the addressed bytes of a valid store change.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_mem_we && w_be[k]) begin
        r_mem[w_idx + ADDR_W'(k)] <= bus.req_wdata[8*k +: 8];
      end
    end
  end

  // FIFO storage; entries need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= bus.req_wdata;
`ifdef DMEM_PROGRAM_DISPLAY_EN
      $display(">>> PROGRAM OUTPUT: %0d", bus.req_wdata);
`endif
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at OUT_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PW'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle response pulse for every accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept && w_err;
      r_rsp_data  <= (w_accept && !w_err && !bus.req_write) ? w_load : 32'h0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_fifo[r_rptr];

endmodule

`default_nettype wire

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, meaning byte-address bits backing RAM; RAM size 2^ADDR_W bytes.
REQ-002 SHALL have parameter MMIO_ADDR, default 32'hFFFF0000, meaning the program-output port address.
REQ-003 SHALL have parameter OUT_DEPTH, default 4, meaning output FIFO entries; power of two, at least 2.
REQ-004 SHALL have one clock and a synchronous active-high reset; ports listed below, clock and reset first.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request can be accepted this cycle.
REQ-009 req_write  in  1  1 = store, 0 = load.
REQ-010 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-012 req_addr  in  32  byte address.
REQ-013 req_wdata  in  32  store data, LSB-aligned.
REQ-014 rsp_valid  out  1  one-cycle response pulse.
REQ-015 rsp_data  out  32  load result; 0 for stores and errors.
REQ-016 rsp_err  out  1  request faulted; valid with rsp_valid.
REQ-017 out_valid, out_data[31:0]  out  1/32  program-output FIFO head.
REQ-018 out_ready  in  1  consumer pops the FIFO head.

Function
REQ-019 Accept = req_valid && req_ready; each accepted request SHALL give exactly one rsp_valid pulse on the next cycle.
REQ-020 req_ready SHALL be 0 only when req_valid, req_write, req_addr==MMIO_ADDR and the FIFO is full; a same-cycle pop SHALL NOT free that slot.
REQ-021 RAM SHALL be little-endian bytes; a store SHALL write only the size bytes at addr..addr+size-1 on the accepting edge.
REQ-022 Load data SHALL be read at accept and registered; byte/half results SHALL be sign- or zero-extended per req_unsigned.
REQ-023 Error cases, each giving rsp_err=1, rsp_data=0 and no state change:
  - req_size==11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr>=2^ADDR_W and addr!=MMIO_ADDR.
REQ-024 A store to MMIO_ADDR SHALL push the full req_wdata word into the FIFO (size ignored, alignment not checked) and SHALL NOT touch RAM.
REQ-025 A load from MMIO_ADDR SHALL return the current FIFO occupancy, 0..OUT_DEPTH, zero-extended.
REQ-026 out_valid SHALL equal FIFO non-empty; out_data SHALL be the oldest entry; a pop occurs on out_valid && out_ready.
REQ-027 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged and preserve order; pointers SHALL wrap modulo OUT_DEPTH.
REQ-028 A store followed by a load of the same address on the next cycle SHALL return the new data.

Reset
REQ-029 Reset SHALL clear rsp_valid, rsp_err, rsp_data, FIFO pointers and occupancy, so out_valid=0.
REQ-030 Reset SHALL NOT alter RAM; RAM SHALL be zero-initialised at simulation start only.
REQ-031 A request presented during reset SHALL be ignored, and a pending response SHALL be dropped.

Configuration
REQ-032 With DMEM_PROGRAM_DISPLAY_EN defined, every MMIO push SHALL print ">>> PROGRAM OUTPUT: <decimal>" on the pushing edge.
REQ-033 Without DMEM_PROGRAM_DISPLAY_EN, no simulation output SHALL be produced; the FIFO behaviour SHALL be identical in both builds.

Verification
REQ-034 Word store 0x80FF7F01 at 0x100, then lb 0x100 / lb 0x102 / lbu 0x102 / lh 0x102 -> 0x00000001, 0xFFFFFFFF, 0x000000FF, 0xFFFF80FF.
REQ-035 sb 0xAA at 0x203 over word 0x11223344 at 0x200, then lw 0x200 -> 0xAA223344, rsp_err=0.
REQ-036 lw 0x102, sh 0x101, size=11, and lw 0x00020000 -> each rsp_err=1, rsp_data=0; RAM unchanged.
REQ-037 With out_ready=0, five MMIO stores 1..5 (OUT_DEPTH=4) -> fifth stalls with req_ready=0; MMIO load is not blocked and returns 4; raising out_ready pops 1,2,3,4 then 5 in order.
REQ-038 Reset while FIFO holds 2 entries and a load is in flight -> out_valid=0 and no rsp_valid next cycle; RAM data stored before reset is still readable.
